// File: rtl/threshold_engine.sv
// Threshold engine: an in-place read/compare/write pass over the pixel bytes of a BMP held in RAM.
// Optional feature macro THRESH_STATS_EN adds the above_cnt output (count of pixels with p > T).
module threshold_engine #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 20,
  parameter int BASE_ADDR   = 0,
  parameter int HEADER_SIZE = 54,
  parameter int TOTAL_SIZE  = 786486
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              gray_done,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] threshold,
  input  logic [DATA_W-1:0] RAM_out,
  output logic              RAM_ren,
  output logic              RAM_wen,
  output logic [DATA_W-1:0] RAM_in,
  output logic [ADDR_W-1:0] RAM_addr,
  output logic              busy,
  output logic              done,
`ifdef THRESH_STATS_EN
  output logic [ADDR_W-1:0] above_cnt,
`endif
  output logic [2:0]        state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR + HEADER_SIZE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + TOTAL_SIZE - 1);
  localparam bit                NO_PIXELS  = (TOTAL_SIZE <= HEADER_SIZE);
  localparam logic [DATA_W-1:0] MAX_VAL    = '1;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   p_q, p_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   thr_q, thr_d;
  logic                start_ok;
  logic                above;
  logic [DATA_W-1:0]   f_val;

  // Abort outranks a start presented in the same IDLE cycle.
  assign start_ok  = (state_q == S_IDLE) && in_valid && gray_done && !abort;
  assign above     = (p_q > thr_q);
  assign RAM_addr  = addr_q;
  assign state_dbg = state_q;

  always_comb begin
    f_val = '0;
    case (mode_q)
      2'd0:    f_val = above ? MAX_VAL : '0;
      2'd1:    f_val = above ? '0 : MAX_VAL;
      2'd2:    f_val = above ? thr_q : p_q;
      default: f_val = above ? p_q : '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    p_d     = p_q;
    mode_d  = mode_q;
    thr_d   = thr_q;
    RAM_ren = 1'b0;
    RAM_wen = 1'b0;
    RAM_in  = '0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          mode_d  = mode;
          thr_d   = threshold;
          addr_d  = FIRST_ADDR;
          state_d = NO_PIXELS ? S_FIN : S_READ;
        end
      end
      S_READ: begin
        busy    = 1'b1;
        RAM_ren = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        p_d     = RAM_out;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy    = 1'b1;
        RAM_wen = 1'b1;
        RAM_in  = f_val;
        if (addr_q == LAST_ADDR) begin
          state_d = S_FIN;
        end else begin
          addr_d  = addr_q + ADDR_W'(1);
          state_d = S_READ;
        end
      end
      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Cancel: no RAM strobe, no done, address and pixel left as they were.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      addr_d  = addr_q;
      p_d     = p_q;
      RAM_ren = 1'b0;
      RAM_wen = 1'b0;
      RAM_in  = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= RESET_ADDR;
      p_q     <= '0;
      mode_q  <= '0;
      thr_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      p_q     <= p_d;
      mode_q  <= mode_d;
      thr_q   <= thr_d;
    end
  end

`ifdef THRESH_STATS_EN
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // RAM_wen is already masked by abort, so a cancelled write is never counted.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok) begin
      cnt_d = '0;
    end else if (RAM_wen && above) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign above_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_threshold_engine.sv
// Bench for threshold_engine: small BMP image in a behavioural RAM, directed and random passes.
// Build with +define+THRESH_STATS_EN to also check above_cnt.
module tb_threshold_engine;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int HDR   = 2;
  localparam int TOT   = 6;
  localparam int NPIX  = TOT - HDR;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, gray_done, abort;
  logic [1:0]    mode;
  logic [DW-1:0] threshold, RAM_out, RAM_in;
  logic          RAM_ren, RAM_wen, busy, done;
  logic [AW-1:0] RAM_addr;
  logic [2:0]    state_dbg;

  // second instance with no pixel bytes at all
  logic          e_start;
  logic          e_ren, e_wen, e_busy, e_done;
  logic [DW-1:0] e_in;
  logic [AW-1:0] e_addr;
  logic [2:0]    e_state;

`ifdef THRESH_STATS_EN
  logic [AW-1:0] above_cnt, e_above_cnt;
`endif

  threshold_engine #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .HEADER_SIZE(HDR), .TOTAL_SIZE(TOT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .gray_done(gray_done), .abort(abort),
    .mode(mode), .threshold(threshold), .RAM_out(RAM_out),
    .RAM_ren(RAM_ren), .RAM_wen(RAM_wen), .RAM_in(RAM_in), .RAM_addr(RAM_addr),
    .busy(busy), .done(done),
`ifdef THRESH_STATS_EN
    .above_cnt(above_cnt),
`endif
    .state_dbg(state_dbg)
  );

  threshold_engine #(.DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(0), .HEADER_SIZE(2), .TOTAL_SIZE(2)) dut_e (
    .clk(clk), .rst_n(rst_n), .in_valid(e_start), .gray_done(e_start), .abort(1'b0),
    .mode(mode), .threshold(threshold), .RAM_out(8'd0),
    .RAM_ren(e_ren), .RAM_wen(e_wen), .RAM_in(e_in), .RAM_addr(e_addr),
    .busy(e_busy), .done(e_done),
`ifdef THRESH_STATS_EN
    .above_cnt(e_above_cnt),
`endif
    .state_dbg(e_state)
  );

  // ---------------- behavioural RAM ----------------
  logic [DW-1:0] mem      [0:15];
  logic [DW-1:0] load_img [0:15];
  logic          load_go;

  always @(posedge clk) begin
    if (load_go) begin
      for (int i = 0; i < 16; i++) mem[i] <= load_img[i];
    end else if (RAM_wen) begin
      mem[RAM_addr[3:0]] <= RAM_in;
    end
    if (RAM_ren) RAM_out <= mem[RAM_addr[3:0]];
  end

  int overlap_n = 0;
  always @(negedge clk) begin
    if ((RAM_ren && RAM_wen) || (e_ren && e_wen)) overlap_n++;
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: pixel transform straight from the mode table.
  function automatic logic [DW-1:0] ref_px(input logic [1:0] m, input logic [DW-1:0] p, input logic [DW-1:0] t);
    bit hi;
    hi = (p > t);
    case (m)
      2'd0:    return hi ? 8'd255 : 8'd0;
      2'd1:    return hi ? 8'd0 : 8'd255;
      2'd2:    return hi ? t : p;
      default: return hi ? p : 8'd0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_image(input logic [DW-1:0] b0, b1, b2, b3, b4, b5);
    for (int i = 0; i < 16; i++) load_img[i] = 8'hEE;
    load_img[0] = b0; load_img[1] = b1; load_img[2] = b2;
    load_img[3] = b3; load_img[4] = b4; load_img[5] = b5;
    load_go = 1'b1;
    @(negedge clk);
    load_go = 1'b0;
  endtask

  task automatic start_pass(input logic [1:0] m, input logic [DW-1:0] t);
    mode = m; threshold = t; in_valid = 1'b1; gray_done = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; gray_done = 1'b0;
  endtask

  // Full pass; expectations come from a snapshot of RAM taken before the start.
  task automatic run_and_check(input string tag, input logic [1:0] m, input logic [DW-1:0] t, input bit perturb);
    int busy_n, done_n, gap, first_rd, last_wr, above_exp;
    bit finished;
    logic [DW-1:0] snap [0:TOT-1];
    busy_n = 0; done_n = 0; gap = -1; first_rd = -1; last_wr = -100; above_exp = 0; finished = 0;
    for (int i = 0; i < TOT; i++) snap[i] = mem[i];
    for (int i = 0; i < TOT; i++) begin
      if (i < HDR) exp_q.push_back(snap[i]);
      else begin
        exp_q.push_back(ref_px(m, snap[i], t));
        if (snap[i] > t) above_exp++;
      end
    end
    start_pass(m, t);
`ifdef THRESH_STATS_EN
    check_eq({tag, "_cnt_cleared"}, 32'(above_cnt), 0);
`endif
    for (int cyc = 0; cyc < 200; cyc++) begin
      if (busy) busy_n++;
      if (RAM_ren && first_rd < 0) first_rd = int'(RAM_addr);
      if (RAM_wen) last_wr = cyc;
      if (done) begin
        done_n++;
        if (gap < 0) gap = cyc - last_wr;
      end
      if (done_n > 0 && !done) begin
        finished = 1;
        break;
      end
      if (perturb) begin
        mode = 2'($urandom_range(0, 3));
        threshold = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
    end
    check_eq({tag, "_finished"}, 32'(finished), 1);
    check_eq({tag, "_busy_cycles"}, busy_n, 3 * NPIX);
    check_eq({tag, "_done_pulses"}, done_n, 1);
    check_eq({tag, "_done_after_last_write"}, gap, 1);
    check_eq({tag, "_first_read_addr"}, first_rd, HDR);
    check_eq({tag, "_idle_after"}, {30'd0, busy, done}, 0);
    for (int i = 0; i < TOT; i++) check_eq($sformatf("%s_mem%0d", tag, i), 32'(mem[i]), 32'(exp_q.pop_front()));
`ifdef THRESH_STATS_EN
    check_eq({tag, "_above_cnt"}, 32'(above_cnt), above_exp);
`endif
  endtask

  // Wait (bounded) for the WAIT cycle (busy, no strobe) or the WRITE cycle of a given address.
  task automatic wait_phase(input bit want_write, input int addr, output bit found);
    found = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (busy && (RAM_addr == AW'(addr)) &&
          (want_write ? RAM_wen : (!RAM_ren && !RAM_wen))) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    int saw_done;
    logic [1:0] rm;
    logic [DW-1:0] rt;

    rst_n = 1'b0; in_valid = 0; gray_done = 0; abort = 0; mode = 0; threshold = 0;
    e_start = 0; load_go = 0;
    for (int i = 0; i < 16; i++) load_img[i] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_ren", 32'(RAM_ren), 0);
    check_eq("rst_wen", 32'(RAM_wen), 0);
    check_eq("rst_ram_in", 32'(RAM_in), 0);
    check_eq("rst_addr", 32'(RAM_addr), 0);
    check_eq("rst_busy_done", {30'd0, busy, done}, 0);
`ifdef THRESH_STATS_EN
    check_eq("rst_above_cnt", 32'(above_cnt), 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed image in all four modes, T=127
    for (int m = 0; m < 4; m++) begin
      load_image(9, 9, 10, 200, 127, 128);
      run_and_check($sformatf("dir_m%0d", m), 2'(m), 8'd127, 0);
    end
    // Spot check of the literal mode-0 result
    load_image(9, 9, 10, 200, 127, 128);
    run_and_check("lit_m0", 2'd0, 8'd127, 0);
    check_eq("lit_m0_bytes", {mem[2], mem[3], mem[4], mem[5]}, {8'd0, 8'd255, 8'd0, 8'd255});

    // Threshold extremes
    load_image(1, 2, 0, 1, 254, 255);
    run_and_check("t_max", 2'd3, 8'd255, 0);
    load_image(1, 2, 0, 1, 254, 255);
    run_and_check("t_zero", 2'd0, 8'd0, 0);

    // Second pass restarts from the current RAM contents (and clears above_cnt)
    run_and_check("repass", 2'd1, 8'd100, 0);

    // Abort in WAIT of the second pixel
    load_image(9, 9, 10, 200, 127, 128);
    start_pass(2'd0, 8'd127);
    wait_phase(0, 3, found);
    check_eq("abort_wait_found", 32'(found), 1);
    abort = 1'b1;
    saw_done = int'(done);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_wait_idle", {30'd0, busy, done}, 0);
    repeat (3) begin
      @(negedge clk);
      saw_done += int'(done);
    end
    check_eq("abort_wait_no_done", saw_done, 0);
    check_eq("abort_wait_mem2", 32'(mem[2]), 0);
    check_eq("abort_wait_mem3_5", {mem[3], mem[4], mem[5]}, {8'd200, 8'd127, 8'd128});

    // Abort in WRITE suppresses the write
    load_image(9, 9, 10, 200, 127, 128);
    start_pass(2'd1, 8'd127);
    wait_phase(1, 2, found);
    check_eq("abort_write_found", 32'(found), 1);
    abort = 1'b1;
    #1;
    check_eq("abort_write_wen", 32'(RAM_wen), 0);
    @(negedge clk);
    abort = 1'b0;
    check_eq("abort_write_mem2", 32'(mem[2]), 10);
    check_eq("abort_write_idle", {30'd0, busy, done}, 0);

    // Asynchronous reset in WRITE of the second pixel, then restart
    load_image(9, 9, 10, 200, 127, 128);
    start_pass(2'd0, 8'd127);
    wait_phase(1, 3, found);
    check_eq("rst_mid_found", 32'(found), 1);
    rst_n = 1'b0;
    #1;
    check_eq("rst_mid_wen", 32'(RAM_wen), 0);
    check_eq("rst_mid_addr", 32'(RAM_addr), 0);
    check_eq("rst_mid_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("rst_mid_mem2_kept", 32'(mem[2]), 0);
    check_eq("rst_mid_mem3_untouched", 32'(mem[3]), 200);
    @(negedge clk);
    run_and_check("rst_restart", 2'd2, 8'd127, 0);

    // Held start: a new pass begins right after the IDLE cycle following FIN
    load_image(9, 9, 10, 200, 127, 128);
    mode = 2'd0; threshold = 8'd127; in_valid = 1'b1; gray_done = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      if (done) begin
        found = 1;
        break;
      end
    end
    check_eq("held_done_seen", 32'(found), 1);
    @(negedge clk);
    check_eq("held_idle_gap", {30'd0, busy, done}, 0);
    @(negedge clk);
    check_eq("held_restart", {30'd0, busy, RAM_ren}, 3);
    check_eq("held_restart_addr", 32'(RAM_addr), HDR);
    abort = 1'b1; in_valid = 1'b0; gray_done = 1'b0;
    @(negedge clk);
    abort = 1'b0;
    check_eq("held_abort_idle", 32'(busy), 0);

    // Empty image: straight to FIN, no RAM strobes
    e_start = 1'b1;
    @(negedge clk);
    e_start = 1'b0;
    check_eq("empty_fin", {29'd0, e_done, e_busy, e_ren}, 4);
    @(negedge clk);
    check_eq("empty_done_once", {29'd0, e_done, e_busy, e_ren}, 0);

    // Random images, modes and thresholds with inputs changing mid-pass
    for (int k = 0; k < 10; k++) begin
      logic [DW-1:0] px [0:3];
      for (int j = 0; j < 4; j++) begin
        case ($urandom_range(0, 3))
          0:       px[j] = 8'd0;
          1:       px[j] = 8'd255;
          default: px[j] = 8'($urandom_range(0, 255));
        endcase
      end
      load_image(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), px[0], px[1], px[2], px[3]);
      rm = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       rt = 8'd0;
        1:       rt = 8'd255;
        default: rt = 8'($urandom_range(0, 255));
      endcase
      run_and_check($sformatf("rnd%0d", k), rm, rt, 1);
    end

    check_eq("ren_wen_overlap", overlap_n, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/threshold_engine.md
THRESHOLD_ENGINE -- requirements
Module: threshold_engine

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning the pixel byte width.
REQ-002 The block SHALL have parameter ADDR_W, default 20, meaning the RAM address width.
REQ-003 The block SHALL have parameter BASE_ADDR, default 0, meaning the address of the first BMP byte.
REQ-004 The block SHALL have parameter HEADER_SIZE, default 54, meaning the number of header bytes, which are never read or written.
REQ-005 The block SHALL have parameter TOTAL_SIZE, default 786486, meaning header plus pixel bytes.
REQ-006 The block SHALL have port clk, input, width 1, the single clock; all logic is rising-edge.
REQ-007 The block SHALL have port rst_n, input, width 1, an asynchronous active-low reset.
REQ-008 The block SHALL have port in_valid, input, width 1, meaning the image is present.
REQ-009 The block SHALL have port gray_done, input, width 1, meaning the upstream grayscale pass is complete.
REQ-010 The block SHALL have port abort, input, width 1, a synchronous cancel.
REQ-011 The block SHALL have port mode, input, width 2, selecting the threshold operation.
REQ-012 The block SHALL have port threshold, input, width DATA_W, the compare value T.
REQ-013 The block SHALL have port RAM_out, input, width DATA_W, the RAM read data, valid one cycle after RAM_ren.
REQ-014 The block SHALL have outputs RAM_ren (1), RAM_wen (1), RAM_in (DATA_W) and RAM_addr (ADDR_W) as the RAM controls.
REQ-015 The block SHALL have outputs busy (1), meaning a pass is in progress, and done (1), meaning the pass is complete.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WAIT, WRITE and FIN.
REQ-017 In IDLE, a sampled in_valid && gray_done SHALL latch mode and threshold, set RAM_addr=BASE_ADDR+HEADER_SIZE and go to READ; mode/threshold changes during a pass have no effect.
REQ-018 READ SHALL assert RAM_ren=1 for 1 cycle, then go to WAIT.
REQ-019 WAIT SHALL drive RAM_ren=0 and RAM_wen=0, capture RAM_out into pixel register p, then go to WRITE.
REQ-020 WRITE SHALL assert RAM_wen=1 with RAM_in=f(p) at the same RAM_addr, giving 3 cycles per pixel.
REQ-021 After WRITE, if RAM_addr==BASE_ADDR+TOTAL_SIZE-1 the FSM SHALL go to FIN, else it SHALL increment RAM_addr and go to READ.
REQ-022 FIN SHALL assert done=1 for exactly 1 cycle, then go to IDLE; RAM_addr holds its last value.
REQ-023 The operation f(p) SHALL use an unsigned compare p>T, with MAX=2^DATA_W-1.
REQ-024 Mode 0 SHALL write MAX if p>T, else 0.
REQ-025 Mode 1 SHALL write 0 if p>T, else MAX.
REQ-026 Mode 2 SHALL write T if p>T, else p.
REQ-027 Mode 3 SHALL write p if p>T, else 0.
REQ-028 busy SHALL be 1 in READ, WAIT and WRITE, and 0 in IDLE and FIN.
REQ-029 RAM_ren and RAM_wen SHALL never be 1 simultaneously.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE on the next edge with no write in that cycle, RAM_wen=0 and no done pulse; abort in IDLE is ignored.
REQ-031 Abort SHALL take priority over the FIN transition and over a start in the same cycle.
REQ-032 A pass with TOTAL_SIZE<=HEADER_SIZE SHALL go IDLE->FIN directly, with no RAM access.
REQ-033 T=MAX SHALL make every compare false; T=0 SHALL make every nonzero p true.
REQ-034 A held start condition SHALL begin a new pass on the cycle after FIN.

Reset
REQ-035 Asserting rst_n=0 SHALL immediately give state IDLE, RAM_ren=0, RAM_wen=0, RAM_in=0, RAM_addr=BASE_ADDR, done=0, busy=0, p=0, latched mode=0 and latched T=0.
REQ-036 Reset mid-pass SHALL abandon the pass; bytes already written remain modified.

Configuration
REQ-037 With THRESH_STATS_EN defined, the block SHALL add output above_cnt, width ADDR_W, reset 0, cleared on start and incremented in each WRITE where p>T, holding its value after FIN until the next start.
REQ-038 With THRESH_STATS_EN undefined, the above_cnt port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 HEADER_SIZE=2, TOTAL_SIZE=6, RAM=[9,9,10,200,127,128], mode 0, T=127 -> RAM=[9,9,0,255,0,255], done 1 cycle after the 4th write, 12 busy cycles.
REQ-040 Same image, modes 1/2/3 -> [..,255,0,255,0] / [..,10,127,127,127] / [..,0,200,0,128].
REQ-041 Assert abort in WAIT of the 2nd pixel -> only addr 2 written, no done, IDLE next cycle, busy=0.
REQ-042 Assert rst_n=0 in WRITE -> RAM_wen=0 and RAM_addr=BASE_ADDR with no clock edge; a restart reprocesses from addr 2.
REQ-043 Change mode/threshold mid-pass -> output unchanged from the latched values; assert RAM_ren&RAM_wen never 1.
REQ-044 With THRESH_STATS_EN and the REQ-039 image -> above_cnt=2 after done; a second pass restarts the count from 0.
